// File: rtl/replay_vote_ctrl.sv
// -----------------------------------------------------------------------------
// replay_vote_ctrl
//   Holds one accepted request and re-issues it while the channel replay vote
//   says replay. Each replay is followed by a fixed back-off, and the request is
//   dropped after MAX_RETRY retries. A request whose vote clears is offered to
//   the downstream consumer until that consumer accepts it.
//
//   Optional build macro: REPLAY_VOTE_STATS_EN adds saturating counters of
//   replay and fail pulses (io_stat_replays, io_stat_fails).
//
// Ports
//   clk            clock
//   reset          asynchronous reset, active low
//   io_valid       request valid
//   io_ready       request accept, high only while idle
//   io_data        request payload (W bits)
//   io_chan_busy   per-channel extra replay cause, used only on an issue cycle
//   io_out_valid   held request is cleared for the consumer
//   io_out_data    held payload
//   io_out_ready   consumer accept
//   io_replay      one-cycle pulse per replay decision
//   io_retry_cnt   retries spent on the current request (CW bits)
//   io_fail        one-cycle pulse when the request is dropped
//   io_stat_replays / io_stat_fails   (REPLAY_VOTE_STATS_EN only)
// -----------------------------------------------------------------------------
module replay_vote_ctrl #(
  parameter int             NCH       = 3,
  parameter int             W         = 8,
  parameter logic [NCH-1:0] MODE_MASK = 3'b100,
  parameter int             COMBINE   = 0,
  parameter int             MAX_RETRY = 4,
  parameter int             BACKOFF   = 2,
  parameter int             CW        = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           io_valid,
  output logic           io_ready,
  input  logic [W-1:0]   io_data,
  input  logic [NCH-1:0] io_chan_busy,
  output logic           io_out_valid,
  output logic [W-1:0]   io_out_data,
  input  logic           io_out_ready,
  output logic           io_replay,
  output logic [CW-1:0]  io_retry_cnt,
  output logic           io_fail
`ifdef REPLAY_VOTE_STATS_EN
  ,
  output logic [15:0]    io_stat_replays,
  output logic [7:0]     io_stat_fails
`endif
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_BACKOFF = 3'd2;
  localparam logic [2:0] S_OUT     = 3'd3;
  localparam logic [2:0] S_FAIL    = 3'd4;

  // The back-off counter is loaded with BACKOFF-1 and the state leaves at 0,
  // so exactly BACKOFF cycles are spent in back-off and the re-issue comes
  // BACKOFF+1 cycles after the issue that decided to replay.
  localparam int            BW      = (BACKOFF > 1) ? $clog2(BACKOFF) : 1;
  localparam logic [BW-1:0] BO_LOAD = BW'(BACKOFF - 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_RETRY);

  logic [2:0]    state_q, state_d;
  logic [W-1:0]  data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bo_q, bo_d;
  logic          ready_q, ready_d;
  logic          out_valid_q, out_valid_d;
  logic          replay_q, replay_d;
  logic          fail_q, fail_d;

  logic [NCH-1:0] chan_replay_s;
  logic           vote_s;

  // Channel replay requests and the combined vote.
  always_comb begin
    chan_replay_s = MODE_MASK | io_chan_busy;
    if (COMBINE != 0) begin
      vote_s = |chan_replay_s;
    end else begin
      vote_s = &chan_replay_s;
    end
  end

  // Next-state, held-data, retry and back-off counter logic.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    bo_d    = bo_q;
    case (state_q)
      S_IDLE: begin
        if (io_valid && ready_q) begin
          data_d  = io_data;
          cnt_d   = {CW{1'b0}};
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (!vote_s) begin
          state_d = S_OUT;
        end else if (cnt_q < MAX_CNT) begin
          cnt_d   = cnt_q + CW'(1);
          bo_d    = BO_LOAD;
          state_d = S_BACKOFF;
        end else begin
          state_d = S_FAIL;
        end
      end
      S_BACKOFF: begin
        if (bo_q == {BW{1'b0}}) begin
          state_d = S_ISSUE;
        end else begin
          bo_d = bo_q - BW'(1);
        end
      end
      S_OUT: begin
        if (io_out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_OUT;
        end
      end
      S_FAIL: begin
        data_d  = {W{1'b0}};
        state_d = S_IDLE;
      end
      default: begin
        data_d  = {W{1'b0}};
        cnt_d   = {CW{1'b0}};
        bo_d    = {BW{1'b0}};
        state_d = S_IDLE;
      end
    endcase
  end

  // Output flags are registered from the next state so they line up with it.
  always_comb begin
    ready_d     = (state_d == S_IDLE);
    out_valid_d = (state_d == S_OUT);
    fail_d      = (state_d == S_FAIL);
    replay_d    = (state_q == S_ISSUE) && (state_d == S_BACKOFF);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      data_q      <= {W{1'b0}};
      cnt_q       <= {CW{1'b0}};
      bo_q        <= {BW{1'b0}};
      ready_q     <= 1'b1;
      out_valid_q <= 1'b0;
      replay_q    <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      bo_q        <= bo_d;
      ready_q     <= ready_d;
      out_valid_q <= out_valid_d;
      replay_q    <= replay_d;
      fail_q      <= fail_d;
    end
  end

  assign io_ready     = ready_q;
  assign io_out_valid = out_valid_q;
  assign io_out_data  = data_q;
  assign io_replay    = replay_q;
  assign io_retry_cnt = cnt_q;
  assign io_fail      = fail_q;

`ifdef REPLAY_VOTE_STATS_EN
  logic [15:0] stat_rep_q;
  logic [7:0]  stat_fail_q;

  // Saturating event counters; each counts the pulse while it is visible.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_rep_q  <= 16'd0;
      stat_fail_q <= 8'd0;
    end else begin
      if (replay_q && (stat_rep_q != 16'hFFFF)) begin
        stat_rep_q <= stat_rep_q + 16'd1;
      end else begin
        stat_rep_q <= stat_rep_q;
      end
      if (fail_q && (stat_fail_q != 8'hFF)) begin
        stat_fail_q <= stat_fail_q + 8'd1;
      end else begin
        stat_fail_q <= stat_fail_q;
      end
    end
  end

  assign io_stat_replays = stat_rep_q;
  assign io_stat_fails   = stat_fail_q;
`endif

endmodule
